// File: rtl/clock_period_monitor.sv
// Clock period monitor: synchronises a slow clk_in into the clk domain, measures its
// period and high time in clk cycles, and flags out-of-tolerance or missing edges.
module clock_period_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EXP_PERIOD = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             meas_en,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             in_range,
  output logic             lost
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FIRST = 2'd1;
  localparam logic [1:0] MEASURE    = 2'd2;
  localparam logic [1:0] LOST       = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       rst_sync;
  logic             rst_int;
  logic             s1, s2, s3;
  logic             rise_det, fall_det;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc, hi_cap;
  logic             range_ok;

  // NOTE: reset asserts asynchronously but releases only after two clk edges,
  // so every flop leaves reset on the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_int = rst | rst_sync[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_det = s2 & ~s3;
  assign fall_det = ~s2 & s3;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    range_ok = 1'b0;
    if (cnt_inc >= EXP_C) range_ok = (cnt_inc - EXP_C) <= TOL_C;
    else                  range_ok = (EXP_C - cnt_inc) <= TOL_C;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_cap       <= '0;
      rise_pulse   <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      lost         <= 1'b0;
    end else begin
      rise_pulse   <= rise_det;
      period_valid <= 1'b0;
      if (!meas_en) begin
        state  <= IDLE;
        cnt    <= '0;
        hi_cap <= '0;
        lost   <= 1'b0;
      end else begin
        cnt <= rise_det ? '0 : cnt_inc;
        case (state)
          IDLE: begin
            state  <= WAIT_FIRST;
            cnt    <= '0;
            hi_cap <= '0;
          end
          WAIT_FIRST: begin
            if (rise_det) begin
              state  <= MEASURE;
              hi_cap <= '0;
            end
          end
          MEASURE: begin
            // A rise on the timeout cycle closes a valid period instead of flagging lost.
            if (rise_det) begin
              period       <= cnt_inc;
              high_time    <= hi_cap;
              in_range     <= range_ok;
              period_valid <= 1'b1;
              hi_cap       <= '0;
            end else begin
              if (fall_det) hi_cap <= cnt_inc;
              if (cnt == TMO_LAST) begin
                state <= LOST;
                lost  <= 1'b1;
              end
            end
          end
          default: begin
            if (rise_det) begin
              state  <= MEASURE;
              lost   <= 1'b0;
              hi_cap <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Self-checking bench for clock_period_monitor: an edge-timestamp model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_clock_period_monitor;

  localparam int CNT_W      = 32;
  localparam int EXP_PERIOD = 8;
  localparam int TOL        = 1;
  localparam int TIMEOUT    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_in = 1'b0;
  logic             meas_en = 1'b0;
  logic             rise_pulse, period_valid, in_range, lost;
  logic [CNT_W-1:0] period, high_time;

  clock_period_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .meas_en(meas_en),
    .rise_pulse(rise_pulse), .period(period), .high_time(high_time),
    .period_valid(period_valid), .in_range(in_range), .lost(lost)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clk_in is seen two edges late; periods are differences of rise edge indices.
  typedef enum {M_OFF, M_WAIT, M_RUN, M_LOST} mode_t;
  mode_t       mode = M_OFF;
  int          edge_n = 0, r_edge = 0, f_edge = 0, rel_cnt = 0, p_m = 0, d_m = 0;
  bit          f_seen = 1'b0, rise_m = 1'b0, fall_m = 1'b0;
  int          smp[$];
  logic        exp_rise = 1'b0, exp_valid = 1'b0, exp_inr = 1'b0, exp_lost = 1'b0;
  logic [31:0] exp_period = '0, exp_high = '0;

  always @(posedge clk or posedge rst) begin
    if (rst || rel_cnt > 0) begin
      rel_cnt    = rst ? 2 : rel_cnt - 1;
      mode       = M_OFF;
      smp        = '{0, 0, 0};
      f_seen     = 1'b0;
      exp_rise   = 1'b0;
      exp_valid  = 1'b0;
      exp_inr    = 1'b0;
      exp_lost   = 1'b0;
      exp_period = '0;
      exp_high   = '0;
    end else begin
      edge_n++;
      rise_m = (smp[1] == 1) && (smp[0] == 0);
      fall_m = (smp[1] == 0) && (smp[0] == 1);
      smp.push_back(int'(clk_in));
      void'(smp.pop_front());
      exp_rise  = rise_m;
      exp_valid = 1'b0;
      if (!meas_en) begin
        mode     = M_OFF;
        exp_lost = 1'b0;
      end else if (mode == M_OFF) begin
        mode = M_WAIT;
      end else if (rise_m) begin
        if (mode == M_RUN) begin
          p_m        = edge_n - r_edge;
          d_m        = (p_m > EXP_PERIOD) ? p_m - EXP_PERIOD : EXP_PERIOD - p_m;
          exp_period = 32'(p_m);
          exp_high   = f_seen ? 32'(f_edge - r_edge) : 32'd0;
          exp_inr    = (d_m <= TOL);
          exp_valid  = 1'b1;
        end
        mode     = M_RUN;
        exp_lost = 1'b0;
        r_edge   = edge_n;
        f_seen   = 1'b0;
      end else if (mode == M_RUN) begin
        if (fall_m) begin
          f_edge = edge_n;
          f_seen = 1'b1;
        end
        if (edge_n - r_edge == TIMEOUT) begin
          mode     = M_LOST;
          exp_lost = 1'b1;
        end
      end
    end
  end

  bit chk_on = 1'b0, lost_prev = 1'b0, lost_seen = 1'b0;
  int ncyc = 0, vcount = 0, rcount = 0, last_rise_n = -1, lost_rise_n = -1;

  always @(negedge clk) begin
    if (chk_on) begin
      ncyc++;
      check("rise_pulse",   32'(rise_pulse),   32'(exp_rise));
      check("period_valid", 32'(period_valid), 32'(exp_valid));
      check("period",       period,            exp_period);
      check("high_time",    high_time,         exp_high);
      check("in_range",     32'(in_range),     32'(exp_inr));
      check("lost",         32'(lost),         32'(exp_lost));
      if (period_valid === 1'b1) vcount++;
      if (rise_pulse === 1'b1) begin
        rcount++;
        last_rise_n = ncyc;
      end
      if (lost === 1'b1 && !lost_prev) lost_rise_n = ncyc;
      if (lost === 1'b1) lost_seen = 1'b1;
      lost_prev = (lost === 1'b1);
    end
  end

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      clk_in = v;
    end
  endtask

  task automatic drive(input int hi, input int lo, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},       period,             32'd0);
    check({tag, "_high_time"},    high_time,          32'd0);
    check({tag, "_period_valid"}, 32'(period_valid),  32'd0);
    check({tag, "_in_range"},     32'(in_range),      32'd0);
    check({tag, "_lost"},         32'(lost),          32'd0);
    check({tag, "_rise_pulse"},   32'(rise_pulse),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int vb, rb;
    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    #1 rst = 1'b0;
    hold(1'b0, 4);
    meas_en = 1'b1;

    // T1: 4/4 waveform, valid from the second rise
    #1 vb = vcount;
    drive(4, 4, 6);
    #1;
    check("t1_valid_count", 32'(vcount - vb), 32'd5);
    check("t1_period",      period,           32'd8);
    check("t1_high_time",   high_time,        32'd4);
    check("t1_in_range",    32'(in_range),    32'd1);

    // T2: 6/6 out of range, then 4/5 back in range
    drive(6, 6, 4);
    #1;
    check("t2_period",    period,        32'd12);
    check("t2_high_time", high_time,     32'd6);
    check("t2_in_range",  32'(in_range), 32'd0);
    drive(4, 5, 4);
    #1;
    check("t2b_period",    period,        32'd9);
    check("t2b_high_time", high_time,     32'd4);
    check("t2b_in_range",  32'(in_range), 32'd1);

    // T3: clk_in stuck low after a rise, then recovery
    vb = vcount;
    lost_rise_n = -1;
    hold(1'b1, 4);
    hold(1'b0, 30);
    #1;
    check("t3_valid_count", 32'(vcount - vb),                32'd1);
    check("t3_lost",        32'(lost),                       32'd1);
    check("t3_lost_delay",  32'(lost_rise_n - last_rise_n),  32'd16);
    vb = vcount;
    drive(4, 4, 3);
    #1;
    check("t3r_lost",        32'(lost),        32'd0);
    check("t3r_valid_count", 32'(vcount - vb), 32'd2);
    check("t3r_period",      period,           32'd8);

    // T4: meas_en dropped mid-period, rises still pulse, then re-enable
    drive(4, 4, 1);
    hold(1'b1, 2);
    meas_en = 1'b0;
    #1 vb = vcount;
    rb = rcount;
    hold(1'b1, 2);
    hold(1'b0, 4);
    drive(4, 4, 2);
    #1;
    check("t4_valid_count", 32'(vcount - vb), 32'd0);
    check("t4_rise_count",  32'(rcount - rb), 32'd3);
    check("t4_period",      period,           32'd8);
    check("t4_lost",        32'(lost),        32'd0);
    meas_en = 1'b1;
    vb = vcount;
    drive(4, 4, 2);
    #1;
    check("t4r_valid_count", 32'(vcount - vb), 32'd1);
    check("t4r_period",      period,           32'd8);

    // T5: asynchronous reset pulse mid-period
    hold(1'b1, 2);
    #2 rst = 1'b1;
    #1 check_zero("t5_rst");
    hold(1'b1, 2);
    hold(1'b0, 2);
    #2 rst = 1'b0;
    vb = vcount;
    hold(1'b0, 4);
    drive(4, 4, 2);
    #1;
    check("t5_valid_count", 32'(vcount - vb), 32'd1);
    check("t5_period",      period,           32'd8);
    check("t5_high_time",   high_time,        32'd4);
    check("t5_in_range",    32'(in_range),    32'd1);

    // T6: period equal to TIMEOUT, rise coincides with the timeout cycle
    lost_seen = 1'b0;
    drive(8, 8, 3);
    #1;
    check("t6_period",    period,         32'd16);
    check("t6_high_time", high_time,      32'd8);
    check("t6_in_range",  32'(in_range),  32'd0);
    check("t6_lost_seen", 32'(lost_seen), 32'd0);
    check("t6_lost",      32'(lost),      32'd0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
